// File: rtl/fetch_issue_unit.sv
// Fetch/issue front end: drives a synchronous instruction memory and issues one word per
// advancing cycle into a three-deep COMMAND window, with branch squash, stall and halt handling.
module fetch_issue_unit #(
    parameter logic [15:0] NOP_WORD = 16'hC0E0,
    parameter logic [3:0]  HLT_FUNC = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        PC_load,
    input  logic [15:0] branch_target,
    output logic [15:0] COMMAND,
    output logic [15:0] BeforeCOMMAND,
    output logic [15:0] TwoBeforeCOMMAND,
    output logic [15:0] cmd_pc,
    output logic        cmd_valid,
    output logic        halted
);

    typedef enum logic [1:0] {FILL, RUN, HALT} state_t;

    state_t      state, n_state;
    logic [15:0] pc, n_pc;
    logic [15:0] fetch_pc, n_fetch_pc;
    logic [15:0] n_command, n_before, n_two_before, n_cmd_pc;
    logic        n_cmd_valid, n_halted;
    // The memory keeps reading pc during a stall, so the word that was in flight is parked here.
    logic [15:0] held_data, n_held_data;
    logic        held_valid, n_held_valid;
    logic [15:0] fetch_word;
    logic        is_hlt;

    assign imem_addr  = pc;
    assign fetch_word = held_valid ? held_data : imem_data;
    assign is_hlt     = (fetch_word[15:14] == 2'b11) && (fetch_word[7:4] == HLT_FUNC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= FILL;
            pc               <= 16'h0000;
            fetch_pc         <= 16'h0000;
            COMMAND          <= NOP_WORD;
            BeforeCOMMAND    <= NOP_WORD;
            TwoBeforeCOMMAND <= NOP_WORD;
            cmd_pc           <= 16'h0000;
            cmd_valid        <= 1'b0;
            halted           <= 1'b0;
            held_data        <= 16'h0000;
            held_valid       <= 1'b0;
        end else begin
            state            <= n_state;
            pc               <= n_pc;
            fetch_pc         <= n_fetch_pc;
            COMMAND          <= n_command;
            BeforeCOMMAND    <= n_before;
            TwoBeforeCOMMAND <= n_two_before;
            cmd_pc           <= n_cmd_pc;
            cmd_valid        <= n_cmd_valid;
            halted           <= n_halted;
            held_data        <= n_held_data;
            held_valid       <= n_held_valid;
        end
    end

    always_comb begin
        n_state      = state;
        n_pc         = pc;
        n_fetch_pc   = fetch_pc;
        n_command    = COMMAND;
        n_before     = BeforeCOMMAND;
        n_two_before = TwoBeforeCOMMAND;
        n_cmd_pc     = cmd_pc;
        n_cmd_valid  = cmd_valid;
        n_halted     = halted;
        n_held_data  = held_data;
        n_held_valid = held_valid;

        if (state == HALT) begin
            // Frozen fetch; the window keeps draining so the HLT shifts out behind bubbles.
            n_two_before = BeforeCOMMAND;
            n_before     = COMMAND;
            n_command    = NOP_WORD;
            n_cmd_valid  = 1'b0;
            n_halted     = 1'b1;
        end else if (!stall) begin
            n_two_before = BeforeCOMMAND;
            n_before     = COMMAND;
            n_fetch_pc   = pc;
            n_held_valid = 1'b0;
            if (PC_load) begin
                n_pc        = branch_target;
                n_command   = NOP_WORD;
                n_cmd_valid = 1'b0;
                n_cmd_pc    = 16'h0000;
                n_state     = FILL;
            end else if (state == FILL) begin
                n_pc        = pc + 16'h0001;
                n_command   = NOP_WORD;
                n_cmd_valid = 1'b0;
                n_cmd_pc    = 16'h0000;
                n_state     = RUN;
            end else begin
                n_command   = fetch_word;
                n_cmd_valid = 1'b1;
                n_cmd_pc    = fetch_pc;
                if (is_hlt) begin
                    n_state = HALT;
                end else begin
                    n_pc = pc + 16'h0001;
                end
            end
        end else if (!held_valid) begin
            n_held_data  = imem_data;
            n_held_valid = 1'b1;
        end
    end

endmodule
